debounce_scan_ctrl: RTL and testbench
=====================================

Name: debounce_scan_ctrl

Overview:
- Multi-channel debounce scheduler that shares one prescaler and one debounce next-state evaluator across NCH switch inputs.
- A round-robin pointer services one channel per clock. Each channel's 3-bit state is held in a register file.
- Produces a debounced level vector plus one-cycle press/release event pulses for downstream control logic.
- Sits between raw board switches and the user FSMs, in place of NCH separate debouncers.

Parameters:
- NCH, 4, number of switch channels (2..16).
- DIV, 8, prescaler period in clk cycles; one tick per DIV cycles; must satisfy DIV >= NCH.
- PW, 3, prescaler counter width; must satisfy 2^PW >= DIV.
- IW, 2, pointer width; must satisfy 2^IW >= NCH.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw  in  NCH  raw asynchronous switch inputs.
- db  out  NCH  debounced levels, registered.
- rise  out  NCH  one-cycle pulse when db[i] goes 0->1.
- fall  out  NCH  one-cycle pulse when db[i] goes 1->0.
- tick  out  1  prescaler tick, high one cycle per DIV cycles.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. rst clears every register immediately:
  - sync flops = 0, prescaler = 0, ptr = 0
  - state[i] = ZERO, pend[i] = 0
  - db = 0, rise = 0, fall = 0, tick = 0
- Synchronizer: 2-flop synchronizer per channel. The evaluator sees sws[i] only, never raw sw.
- Prescaler: counts 0..DIV-1 and wraps to 0. tick is registered high in the cycle after the count equals DIV-1, so the tick period is exactly DIV.
- Pending flags:
  - On tick, pend[i] is set for every channel.
  - When ptr == i, pend[i] is consumed (cleared).
  - If tick and service of channel i coincide, pend[i] ends the cycle set; the new tick is not lost.
- Pointer: increments every clk and wraps NCH-1 -> 0. Each channel is serviced exactly once per NCH cycles.
- Channel FSM, evaluated only for channel ptr each cycle; check = pend[ptr]:
  - ZERO: sws -> W1_1.
  - W1_1, W1_2, W1_3: !sws -> ZERO; else if check, advance (W1_3 advances to ONE).
  - ONE: !sws -> W0_1.
  - W0_1, W0_2, W0_3: sws -> ONE; else if check, advance (W0_3 advances to ZERO).
  - No other transitions. Unserviced channels hold state.
- Outputs:
  - db[i] = 1 in ONE and W0_x states, 0 otherwise; registered, updated the cycle after service.
  - rise[i] is high for the one cycle after the W1_3->ONE transition is written.
  - fall[i] is high for the one cycle after the W0_3->ZERO transition is written.
  - rise and fall are never both high for the same channel.
- Latency: a clean edge held stable produces a db change between 2*DIV+2 and 4*DIV+NCH+2 cycles after the sw edge. Any bounce back to the old level during W states returns the channel to its stable state with no output change.
- Reset mid-operation: all channels return to ZERO and db drops to 0 asynchronously. No rise/fall pulse is generated by reset.
- Simultaneous events: multiple channels may complete in the same ptr sweep. Pulses are serialized, at most one channel event per cycle, by construction.

Decomposition:
- Shared package:
  - state encodings ZERO=000, W1_1=001, W1_2=010, W1_3=011, ONE=100, W0_1=101, W0_2=110, W0_3=111
  - a helper constant for the state width (3)
  - db is state bit 2.
- Natural sub-module: deb_prescaler (PW-bit counter plus registered tick output).
- State register file, pend, ptr and the next-state evaluator stay in the top module.

Test Plan (NCH=4, DIV=8):
1. Reset then idle: sw=0000 for 200 cycles -> db=0000, rise=fall=0000 throughout, tick high every 8th cycle.
2. Clean press: sw[1] 0->1 and held -> db[1]=1 within 18..38 cycles, exactly one rise[1] pulse, other channels unchanged.
3. Bounce: sw[2] toggles every 5 cycles for 60 cycles, then held 1 -> no db[2] change during toggling; db[2]=1 and a single rise[2] after stabilization.
4. Release glitch: db[0]=1, sw[0] drops low for 6 cycles then returns high -> db[0] stays 1, no fall[0]; a sustained release gives exactly one fall[0].
5. Simultaneous: sw 0000->1111 at one cycle -> all db bits reach 1; the four rise pulses occur in different cycles, ordered by channel ptr order.
6. Async reset mid-debounce: rst asserted while channel 3 is in W1_2 and db[0]=1 -> db=0000 immediately with no clock edge; after release, channels re-debounce from ZERO.

Source files
------------

// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared definitions for the time-multiplexed switch debouncer.
package debounce_scan_ctrl_pkg;

    localparam int STATE_W = 3;

    // Bit 2 is the debounced level. The low two bits count confirmed ticks.
    typedef enum logic [STATE_W-1:0] {
        ZERO = 3'b000,
        W1_1 = 3'b001,
        W1_2 = 3'b010,
        W1_3 = 3'b011,
        ONE  = 3'b100,
        W0_1 = 3'b101,
        W0_2 = 3'b110,
        W0_3 = 3'b111
    } deb_state_t;

    function automatic logic db_level(input deb_state_t s);
        return s[2];
    endfunction

endpackage

// File: rtl/debounce_scan_ctrl_prescaler.sv
// Shared prescaler: free-running modulo-DIV counter with a registered tick.
module deb_prescaler #(
    parameter int DIV = 8,
    parameter int PW  = 3
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [PW-1:0] cnt;
    logic          at_top;

    assign at_top = (cnt == PW'(DIV - 1));

    // Count 0..DIV-1 and register tick from the terminal count, so ticks are exactly DIV apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= at_top ? '0 : cnt + 1'b1;
            tick <= at_top;
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debouncer: one shared evaluator services one channel per clock.
//
// state | meaning
// ZERO  | stable low
// W1_1  | high seen, waiting for 1st confirming tick
// W1_2  | high seen, waiting for 2nd confirming tick
// W1_3  | high seen, waiting for 3rd confirming tick
// ONE   | stable high
// W0_1  | low seen, waiting for 1st confirming tick
// W0_2  | low seen, waiting for 2nd confirming tick
// W0_3  | low seen, waiting for 3rd confirming tick
module debounce_scan_ctrl
    import debounce_scan_ctrl_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DIV = 8,
    parameter int PW  = 3,
    parameter int IW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] sw,
    output logic [NCH-1:0] db,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           tick
);

    logic [NCH-1:0] sw_meta;
    logic [NCH-1:0] sws;
    logic [NCH-1:0] pend;
    logic [IW-1:0]  ptr;
    deb_state_t     state [NCH];
    deb_state_t     cur;
    deb_state_t     nxt;
    logic           check;
    logic           cur_sw;

    deb_prescaler #(
        .DIV (DIV),
        .PW  (PW)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer and the round-robin service pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sws     <= '0;
            ptr     <= '0;
        end else begin
            sw_meta <= sw;
            sws     <= sw_meta;
            ptr     <= (ptr == IW'(NCH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Pending-tick flags: a fresh tick outranks consumption so it is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (tick)
                    pend[i] <= 1'b1;
                else if (ptr == IW'(i))
                    pend[i] <= 1'b0;
            end
        end
    end

    // Shared next-state evaluator for the channel under service.
    always_comb begin
        cur    = state[ptr];
        check  = pend[ptr];
        cur_sw = sws[ptr];
        nxt    = cur;
        unique case (cur)
            ZERO: if (cur_sw) nxt = W1_1;
            W1_1: if (!cur_sw) nxt = ZERO; else if (check) nxt = W1_2;
            W1_2: if (!cur_sw) nxt = ZERO; else if (check) nxt = W1_3;
            W1_3: if (!cur_sw) nxt = ZERO; else if (check) nxt = ONE;
            ONE:  if (!cur_sw) nxt = W0_1;
            W0_1: if (cur_sw) nxt = ONE; else if (check) nxt = W0_2;
            W0_2: if (cur_sw) nxt = ONE; else if (check) nxt = W0_3;
            W0_3: if (cur_sw) nxt = ONE; else if (check) nxt = ZERO;
            default: nxt = ZERO;
        endcase
    end

    // State file write-back plus registered level and edge pulses for the serviced channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++)
                state[i] <= ZERO;
            db   <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            state[ptr] <= nxt;
            db[ptr]    <= db_level(nxt);
            rise       <= '0;
            fall       <= '0;
            rise[ptr]  <= (cur == W1_3) && (nxt == ONE);
            fall[ptr]  <= (cur == W0_3) && (nxt == ZERO);
        end
    end

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl with NCH=4, DIV=8.
module tb_debounce_scan_ctrl;

    localparam int NCH = 4;
    localparam int DIV = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] sw;
    logic [NCH-1:0] db;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic           tick;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int rise_cnt [NCH];
    int fall_cnt [NCH];
    int rise_cyc [NCH];
    int both_err = 0;

    debounce_scan_ctrl #(
        .NCH (NCH),
        .DIV (DIV),
        .PW  (3),
        .IW  (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .db   (db),
        .rise (rise),
        .fall (fall),
        .tick (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rise[i] === 1'b1) begin
                rise_cnt[i] = rise_cnt[i] + 1;
                rise_cyc[i] = cyc;
            end
            if (fall[i] === 1'b1) fall_cnt[i] = fall_cnt[i] + 1;
            if (rise[i] === 1'b1 && fall[i] === 1'b1) both_err = both_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_db(input int ch, input logic lvl, input int budget, output int lat);
        int c0;
        c0  = cyc;
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (db[ch] === lvl) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    task automatic wait_all(input logic [NCH-1:0] val, input int budget, output int lat);
        int c0;
        c0  = cyc;
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (db === val) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    // Returns just after an edge where tick is observed high; prescaler and ptr are then in phase (ptr=0).
    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 2 * DIV; k++) begin
            step();
            if (tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("tick_seen", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int bad, tcnt, tbad, last, lat, chg, c0, m;
        int rs [NCH];
        int fs [NCH];
        logic ordered;

        rst = 1'b1;
        sw  = '0;
        repeat (3) step();
        check("rst_db",   {28'd0, db},   32'd0);
        check("rst_rise", {28'd0, rise}, 32'd0);
        check("rst_fall", {28'd0, fall}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        rst = 1'b0;

        // 1: idle, tick period
        bad = 0; tcnt = 0; tbad = 0; last = -1;
        repeat (200) begin
            step();
            if ((db | rise | fall) !== '0) bad++;
            if (tick === 1'b1) begin
                tcnt++;
                if (last >= 0 && (cyc - last) != DIV) tbad++;
                last = cyc;
            end
        end
        check("idle_outputs", bad, 0);
        check("idle_tick_count", tcnt, 25);
        check("idle_tick_period", tbad, 0);

        // 2: clean press on ch1, launched in phase with a tick
        rs[1] = rise_cnt[1];
        wait_tick();
        c0 = cyc;
        sw[1] = 1'b1;
        wait_db(1, 1'b1, 60, lat);
        check("press_latency", lat, 26);
        check("press_window", {31'd0, (lat >= 18 && lat <= 38)}, 32'd1);
        repeat (4) step();
        check("press_rise_count", rise_cnt[1] - rs[1], 1);
        check("press_rise_cycle", rise_cyc[1] - c0, 26);
        check("press_db", {28'd0, db}, 32'h2);

        // 3: bounce on ch2
        rs[2] = rise_cnt[2];
        chg = 0;
        for (int k = 0; k < 12; k++) begin
            sw[2] = ~sw[2];
            repeat (5) begin
                step();
                if (db[2] !== 1'b0) chg++;
            end
        end
        check("bounce_no_change", chg, 0);
        check("bounce_no_rise", rise_cnt[2] - rs[2], 0);
        sw[2] = 1'b1;
        wait_db(2, 1'b1, 60, lat);
        check("bounce_settle", {31'd0, (lat >= 18 && lat <= 38)}, 32'd1);
        repeat (4) step();
        check("bounce_rise_count", rise_cnt[2] - rs[2], 1);
        check("bounce_db", {28'd0, db}, 32'h6);

        // 4: release glitch then sustained release on ch0
        sw[0] = 1'b1;
        wait_db(0, 1'b1, 60, lat);
        check("ch0_up", {31'd0, (lat >= 18 && lat <= 38)}, 32'd1);
        repeat (4) step();
        fs[0] = fall_cnt[0];
        sw[0] = 1'b0;
        repeat (6) step();
        sw[0] = 1'b1;
        chg = 0;
        repeat (50) begin
            step();
            if (db[0] !== 1'b1) chg++;
        end
        check("glitch_db_hold", chg, 0);
        check("glitch_no_fall", fall_cnt[0] - fs[0], 0);
        wait_tick();
        sw[0] = 1'b0;
        wait_db(0, 1'b0, 60, lat);
        check("release_latency", lat, 29);
        repeat (4) step();
        check("release_fall_count", fall_cnt[0] - fs[0], 1);
        check("release_db", {28'd0, db}, 32'h6);

        // 5: simultaneous press on all channels from a clean reset
        sw = '0;
        step();
        rst = 1'b1;
        step();
        check("rst2_db", {28'd0, db}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < NCH; i++) rs[i] = rise_cnt[i];
        for (int i = 0; i < NCH; i++) fs[i] = fall_cnt[i];
        sw = '1;
        wait_all(4'hF, 60, lat);
        check("simul_all_up", {31'd0, (lat >= 18 && lat <= 38)}, 32'd1);
        repeat (4) step();
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("simul_rise%0d", i), rise_cnt[i] - rs[i], 1);
            check($sformatf("simul_nofall%0d", i), fall_cnt[i] - fs[i], 0);
        end
        m = 0;
        for (int i = 1; i < NCH; i++) if (rise_cyc[i] < rise_cyc[m]) m = i;
        ordered = 1'b1;
        for (int k = 1; k < NCH; k++)
            if (rise_cyc[(m + k) % NCH] <= rise_cyc[(m + k - 1) % NCH]) ordered = 1'b0;
        check("simul_ptr_order", {31'd0, ordered}, 32'd1);

        // 6: async reset with ch3 in W1_2 and ch0 high
        sw[3] = 1'b0;
        wait_db(3, 1'b0, 60, lat);
        check("ch3_down", {31'd0, (lat >= 18 && lat <= 38)}, 32'd1);
        wait_tick();
        sw[3] = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("pre_reset_db", {28'd0, db}, 32'h7);
        for (int i = 0; i < NCH; i++) rs[i] = rise_cnt[i];
        for (int i = 0; i < NCH; i++) fs[i] = fall_cnt[i];
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_db",   {28'd0, db},   32'd0);
        check("async_rst_rise", {28'd0, rise}, 32'd0);
        check("async_rst_fall", {28'd0, fall}, 32'd0);
        step();
        rst = 1'b0;
        chg = 0;
        repeat (17) begin
            step();
            if (db !== '0) chg++;
        end
        check("redebounce_hold", chg, 0);
        wait_all(4'hF, 40, lat);
        check("redebounce_done", {31'd0, (lat > 0)}, 32'd1);
        repeat (4) step();
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("redeb_rise%0d", i), rise_cnt[i] - rs[i], 1);
            check($sformatf("redeb_nofall%0d", i), fall_cnt[i] - fs[i], 0);
        end

        check("rise_fall_exclusive", both_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
